// File: rtl/mmu_clkgen.sv
// 6809E E/Q clock generator with MRDY stretch and SLOW-device wait states.
// Optional define STRETCH_TIMEOUT_EN bounds a stretch at STRETCH_MAX and flags TIMEOUT.
module mmu_clkgen #(
   parameter int unsigned WAIT_SLOW   = 4,
   parameter int unsigned STRETCH_MAX = 40
) (
   input  logic CLKX4,
   input  logic nRESET,
   input  logic MRDY,
   input  logic SLOW,
   output logic QX,
   output logic EX,
   output logic STRETCH,
   output logic TIMEOUT
);

   localparam int unsigned CMAX = (WAIT_SLOW > STRETCH_MAX) ? WAIT_SLOW : STRETCH_MAX;
   localparam int unsigned CW   = (CMAX == 0) ? 1 : $clog2(CMAX + 1);

   // State encoding is {EX,QX} so the clock outputs come straight off the state flops.
   typedef enum logic [1:0] {
      P0 = 2'b00,
      P1 = 2'b01,
      P2 = 2'b11,
      P3 = 2'b10
   } phase_e;

   phase_e          state_q, state_d;
   logic            sync1_q, sync2_q;
   logic [CW-1:0]   slow_q, slow_d;
   logic [CW-1:0]   str_q, str_d;
   logic            stretch_q, stretch_d;
   logic            release_c;

   assign release_c = sync2_q && (slow_q == '0);

`ifdef STRETCH_TIMEOUT_EN
   logic timeout_q, timeout_d;
   logic limit_c;

   assign limit_c = (str_q == CW'(STRETCH_MAX));
`endif

   always_comb begin
      state_d   = state_q;
      slow_d    = slow_q;
      str_d     = str_q;
`ifdef STRETCH_TIMEOUT_EN
      timeout_d = timeout_q;
`endif
      case (state_q)
         P0: state_d = P1;
         P1: begin
            state_d = P2;
            slow_d  = SLOW ? CW'(WAIT_SLOW) : '0;
         end
         P2: begin
            state_d = P3;
            str_d   = '0;
         end
         P3: begin
            if (slow_q != '0) slow_d = slow_q - CW'(1);
`ifdef STRETCH_TIMEOUT_EN
            if (release_c || limit_c) begin
               state_d = P0;
               if (!release_c) timeout_d = 1'b1;
            end else if (str_q != '1) begin
               str_d = str_q + CW'(1);
            end
`else
            if (release_c) state_d = P0;
            else if (str_q != '1) str_d = str_q + CW'(1);
`endif
         end
      endcase
      stretch_d = (state_d == P3) && (str_d != '0);
   end

   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         state_q   <= P0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         slow_q    <= '0;
         str_q     <= '0;
         stretch_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= MRDY;
         sync2_q   <= sync1_q;
         slow_q    <= slow_d;
         str_q     <= str_d;
         stretch_q <= stretch_d;
      end
   end

`ifdef STRETCH_TIMEOUT_EN
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) timeout_q <= 1'b0;
      else         timeout_q <= timeout_d;
   end

   assign TIMEOUT = timeout_q;
`else
   assign TIMEOUT = 1'b0;
`endif

   assign EX      = state_q[1];
   assign QX      = state_q[0];
   assign STRETCH = stretch_q;

endmodule

// File: doc/mmu_clkgen.md
MMU_CLKGEN -- requirements
Module: mmu_clkgen

Interface
REQ-001 Parameter WAIT_SLOW, default 4: extra CLKX4 cycles of E-high added when SLOW is sampled high.
REQ-002 Parameter STRETCH_MAX, default 40: maximum extra CLKX4 cycles of E-high per bus cycle, used only when STRETCH_TIMEOUT_EN is defined.
REQ-003 CLKX4  input  1  master clock at 4x the nominal E rate; single clock domain; all state changes on the rising edge.
REQ-004 nRESET  input  1  asynchronous, active-low reset.
REQ-005 MRDY  input  1  memory ready from the external bus; low requests E stretch; asynchronous to CLKX4.
REQ-006 SLOW  input  1  slow-device select from the address decoder; valid from Q rise.
REQ-007 QX  output  1  6809E Q clock, registered.
REQ-008 EX  output  1  6809E E clock, registered.
REQ-009 STRETCH  output  1  high while E is held beyond its nominal high time.
REQ-010 TIMEOUT  output  1  sticky flag: a stretch was force-terminated.

Function
REQ-011 Phase FSM states and outputs (EX,QX): P0=(0,0), P1=(0,1), P2=(1,1), P3=(1,0); Q leads E by one CLKX4 period.
REQ-012 FSM transitions: P0->P1->P2->P3 unconditionally, one CLKX4 each; P3->P0 only when the release condition holds, else stay in P3.
REQ-013 Release condition: synchronised MRDY high AND slow counter zero (AND, under STRETCH_TIMEOUT_EN, stretch limit not reached; reaching the limit forces release).
REQ-014 With MRDY high and SLOW low, the period is exactly 4 CLKX4 cycles, E high 2, Q high 2.
REQ-015 MRDY passes through a two-flop synchroniser; release decisions use the second flop only; the synchroniser resets to 1.
REQ-016 SLOW sampled once per bus cycle on the P1->P2 edge; if high, slow counter loads WAIT_SLOW, else 0.
REQ-017 Slow counter decrements by 1 on each edge spent in P3 while nonzero; it never wraps below 0.
REQ-018 Stretch counter clears on entry to P3 and increments each edge the FSM remains in P3; saturates, never wraps.
REQ-019 STRETCH is high exactly when FSM is in P3 and stretch counter is nonzero; it is registered and clear in P0..P2.
REQ-020 Simultaneous MRDY low and SLOW high: E high lasts until both are satisfied, i.e. max of the two requirements, not their sum.
REQ-021 QX and EX are driven directly from state flops; they carry no combinational decode and are glitch-free.
REQ-022 Counter widths are sized to hold max(WAIT_SLOW, STRETCH_MAX) without overflow.

Reset
REQ-023 nRESET low asynchronously forces state P0, QX=0, EX=0, STRETCH=0, TIMEOUT=0, both counters 0, and the synchroniser to 1.
REQ-024 Reset asserted mid-stretch abandons the cycle immediately, leaving no residual count.
REQ-025 After nRESET rises, the first CLKX4 edge moves P0->P1; clocks free-run from then on.

Configuration
REQ-026 Macro STRETCH_TIMEOUT_EN defined: the stretch counter reaching STRETCH_MAX forces P3->P0 on that edge and sets TIMEOUT, which stays set until reset.
REQ-027 Macro STRETCH_TIMEOUT_EN undefined: stretch is unbounded while MRDY is low; TIMEOUT is tied 0; no limit comparator is built.

Verification
REQ-028 Reset released, MRDY=1, SLOW=0 -> EX/QX sequence 00,01,11,10 repeating with period 4 CLKX4; STRETCH=0 throughout.
REQ-029 SLOW=1 at P1->P2, WAIT_SLOW=4, MRDY=1 -> EX high 6 cycles, period 8, STRETCH high 4 cycles; the next cycle with SLOW=0 is back to period 4.
REQ-030 MRDY driven low 3 cycles before E rise and held 10 cycles -> E held high until 2 cycles after MRDY rises; STRETCH high during the hold; TIMEOUT=0.
REQ-031 STRETCH_TIMEOUT_EN, STRETCH_MAX=40, MRDY held low -> E high exactly 42 cycles, then P0; TIMEOUT=1 and stays 1 across later normal cycles until nRESET.
REQ-032 nRESET pulsed low during a 20-cycle stretch -> QX=EX=STRETCH=0 immediately; after release, a normal 4-cycle period with no leftover stretch.
